output_arbiter_w: RTL and testbench

//  West output port of a 5-port mesh router. Collects one-cycle requests from
//  the E, N, S and PE input routing units, grants them in token-ring order,

---
 rtl/noc_pkg.sv | 34 +++
 rtl/output_arbiter_w_if.sv | 37 +++
 rtl/noc_sync_fifo.sv | 58 +++++
 rtl/output_arbiter_w_chk.sv | 17 +
 rtl/output_arbiter_w.sv | 92 +++++++++
 tb/tb_output_arbiter_w.sv | 216 +++++++++++++++++++++
 6 files changed

// File: rtl/noc_pkg.sv
// Shared mesh-router definitions: packet width, routing field positions,
// port identifiers and the output-port token ring order.
package noc_pkg;

    localparam int DATA_W     = 64;
    localparam int FIFO_DEPTH = 4;

    localparam int DIR_X    = 58;
    localparam int DIR_Y    = 57;
    localparam int HOP_X_HI = 56;
    localparam int HOP_X_LO = 55;
    localparam int HOP_Y_HI = 54;
    localparam int HOP_Y_LO = 53;

    typedef enum logic [2:0] {
        P_E  = 3'd0,
        P_N  = 3'd1,
        P_S  = 3'd2,
        P_PE = 3'd3,
        P_W  = 3'd4
    } port_e;

    // Token order for the west output: E -> N -> S -> PE -> E
    function automatic port_e next_owner(input port_e cur);
        case (cur)
            P_E:     next_owner = P_N;
            P_N:     next_owner = P_S;
            P_S:     next_owner = P_PE;
            P_PE:    next_owner = P_E;
            default: next_owner = P_E;
        endcase
    endfunction

endpackage

// File: rtl/output_arbiter_w_if.sv
// Request/backpressure and downstream write bundle of the west output port.
// slave = the arbiter, master = routing units plus downstream neighbour.
interface output_arbiter_w_if #(parameter int DATA_W = noc_pkg::DATA_W);

    logic              E_req;
    logic              N_req;
    logic              S_req;
    logic              PE_req;
    logic [DATA_W-1:0] E_packet;
    logic [DATA_W-1:0] N_packet;
    logic [DATA_W-1:0] S_packet;
    logic [DATA_W-1:0] PE_packet;
    logic              full_E;
    logic              full_N;
    logic              full_S;
    logic              full_PE;
    logic              ds_full;
    logic              out_wr_en;
    logic [DATA_W-1:0] out_packet;

    modport master (
        output E_req, N_req, S_req, PE_req,
        output E_packet, N_packet, S_packet, PE_packet,
        output ds_full,
        input  full_E, full_N, full_S, full_PE,
        input  out_wr_en, out_packet
    );

    modport slave (
        input  E_req, N_req, S_req, PE_req,
        input  E_packet, N_packet, S_packet, PE_packet,
        input  ds_full,
        output full_E, full_N, full_S, full_PE,
        output out_wr_en, out_packet
    );

endinterface

// File: rtl/noc_sync_fifo.sv
// Small synchronous FIFO shared by router ports. DEPTH must be a power of 2
// so pointers wrap naturally; head always shows the entry at the read pointer.
module noc_sync_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [DATA_W-1:0] head_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              wr_ok_s;
    logic              rd_ok_s;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == {CNT_W{1'b0}});
    assign wr_ok_s = wr_en_i & ~full_o;
    assign rd_ok_s = rd_en_i & ~empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    // Storage, pointers and occupancy; reset clears memory so no stale data is visible
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= {PTR_W{1'b0}};
            wr_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            if (wr_ok_s) begin
                mem_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (rd_ok_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({wr_ok_s, rd_ok_s})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/output_arbiter_w_chk.sv
// Simulation checks on the routing-unit side of the west output port.
module output_arbiter_w_chk (
    input logic       clk,
    input logic       reset,
    input logic [3:0] req_i,
    input logic [3:0] full_i
);

    // A routing unit may only request while its own full flag is low
    property p_req_gated;
        @(posedge clk) disable iff (reset) ((req_i & full_i) == 4'b0000);
    endproperty

    a_req_gated: assert property (p_req_gated)
        else $error("output_arbiter_w: req raised while full");

endmodule

// File: rtl/output_arbiter_w.sv
// West output port: token-ring arbitration over E/N/S/PE requests, a small
// output FIFO, and drain into the neighbour's west-facing input FIFO.
import noc_pkg::*;

module output_arbiter_w #(
    parameter int DATA_W     = noc_pkg::DATA_W,
    parameter int FIFO_DEPTH = noc_pkg::FIFO_DEPTH
) (
    input  logic               clk,
    input  logic               reset,
    output_arbiter_w_if.slave  bus
);

    port_e             owner_q;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic              owner_req_s;
    logic [DATA_W-1:0] owner_pkt_s;
    logic              wr_en_s;
    logic              rd_en_s;

    // Only the token owner's request and packet reach the FIFO
    always_comb begin
        owner_req_s = 1'b0;
        owner_pkt_s = {DATA_W{1'b0}};
        case (owner_q)
            P_E: begin
                owner_req_s = bus.E_req;
                owner_pkt_s = bus.E_packet;
            end
            P_N: begin
                owner_req_s = bus.N_req;
                owner_pkt_s = bus.N_packet;
            end
            P_S: begin
                owner_req_s = bus.S_req;
                owner_pkt_s = bus.S_packet;
            end
            P_PE: begin
                owner_req_s = bus.PE_req;
                owner_pkt_s = bus.PE_packet;
            end
            default: begin
                owner_req_s = 1'b0;
                owner_pkt_s = {DATA_W{1'b0}};
            end
        endcase
    end

    assign wr_en_s = owner_req_s & ~fifo_full_s;
    assign rd_en_s = ~fifo_empty_s & ~bus.ds_full;

    // Backpressure comes from registers only, so req never loops back into full
    assign bus.full_E    = (owner_q != P_E)  | fifo_full_s;
    assign bus.full_N    = (owner_q != P_N)  | fifo_full_s;
    assign bus.full_S    = (owner_q != P_S)  | fifo_full_s;
    assign bus.full_PE   = (owner_q != P_PE) | fifo_full_s;
    assign bus.out_wr_en = rd_en_s;

    // Token advances every cycle with room in the FIFO, freezes while it is full
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q <= P_E;
        end else if (!fifo_full_s) begin
            owner_q <= next_owner(owner_q);
        end else begin
            owner_q <= owner_q;
        end
    end

    noc_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (wr_en_s),
        .wr_data_i (owner_pkt_s),
        .rd_en_i   (rd_en_s),
        .full_o    (fifo_full_s),
        .empty_o   (fifo_empty_s),
        .head_o    (bus.out_packet)
    );

    output_arbiter_w_chk u_chk (
        .clk    (clk),
        .reset  (reset),
        .req_i  ({bus.PE_req, bus.S_req, bus.N_req, bus.E_req}),
        .full_i ({bus.full_PE, bus.full_S, bus.full_N, bus.full_E})
    );

endmodule

// File: tb/tb_output_arbiter_w.sv
// Bench for output_arbiter_w: directed vector table, multi-cycle sequences,
// and random traffic checked against a queue-based reference model.
module tb_output_arbiter_w;

    localparam int DW    = 64;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    output_arbiter_w_if #(.DATA_W(DW)) bus ();

    output_arbiter_w #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [3:0] dut_full_s;
    assign dut_full_s = {bus.full_PE, bus.full_S, bus.full_N, bus.full_E};

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: owner index 0..3 (E,N,S,PE) and a queue of buffered packets
    logic [DW-1:0] mq[$];
    int            m_owner = 0;
    bit            m_valid = 1'b0;
    logic [DW-1:0] emitted[$];

    logic          cur_rst;
    logic [3:0]    cur_req;
    logic [DW-1:0] cur_pk [4];
    logic          cur_ds;

    typedef struct {
        logic          rst;
        logic [3:0]    req;
        logic [63:0]   pkt;
        logic          ds;
        bit            chk;
        logic [3:0]    e_full;
        logic          e_wr;
        bit            chk_pkt;
        logic [63:0]   e_pkt;
    } vec_t;

    vec_t tbl [11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle: drive at negedge, compare before the edge, update model after it
    task automatic step(input bit tchk, input logic [3:0] tfull, input logic twr,
                        input bit tchkp, input logic [63:0] tpkt);
        logic [3:0] exp_full;
        logic       exp_wr;
        bit         was_full;
        exp_full = 4'b0000;
        exp_wr   = 1'b0;
        reset         = cur_rst;
        bus.E_req     = cur_req[0];
        bus.N_req     = cur_req[1];
        bus.S_req     = cur_req[2];
        bus.PE_req    = cur_req[3];
        bus.E_packet  = cur_pk[0];
        bus.N_packet  = cur_pk[1];
        bus.S_packet  = cur_pk[2];
        bus.PE_packet = cur_pk[3];
        bus.ds_full   = cur_ds;
        #1;
        if (tchk) begin
            check("vec_full", 64'(dut_full_s), 64'(tfull));
            check("vec_wr_en", 64'(bus.out_wr_en), 64'(twr));
            if (tchkp) check("vec_pkt", bus.out_packet, tpkt);
        end
        if (m_valid) begin
            for (int x = 0; x < 4; x++) exp_full[x] = (m_owner != x) || (mq.size() == DEPTH);
            exp_wr = (mq.size() > 0) && !cur_ds;
            check("model_full", 64'(dut_full_s), 64'(exp_full));
            check("model_wr_en", 64'(bus.out_wr_en), 64'(exp_wr));
            if (mq.size() > 0) check("model_pkt", bus.out_packet, mq[0]);
        end
        if (bus.out_wr_en === 1'b1) emitted.push_back(bus.out_packet);
        @(posedge clk);
        if (cur_rst) begin
            mq.delete();
            m_owner = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            was_full = (mq.size() == DEPTH);
            if (exp_wr) void'(mq.pop_front());
            if (cur_req[m_owner] && !was_full) mq.push_back(cur_pk[m_owner]);
            if (!was_full) m_owner = (m_owner + 1) % 4;
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic rst, input logic ds, input int n);
        for (int k = 0; k < n; k++) begin
            cur_rst = rst;
            cur_req = 4'b0000;
            cur_ds  = ds;
            step(1'b0, 4'b0000, 1'b0, 1'b0, 64'h0);
        end
    endtask

    // Each input raises req only while its own full flag is low
    task automatic stream(input logic [DW-1:0] pkts[$], input logic ds, input int cycles,
                          output int sent);
        int idx;
        idx = 0;
        for (int k = 0; k < cycles; k++) begin
            cur_rst = 1'b0;
            cur_req = 4'b0000;
            cur_ds  = ds;
            for (int x = 0; x < 4; x++) begin
                if (idx < pkts.size() && dut_full_s[x] == 1'b0) begin
                    cur_req[x] = 1'b1;
                    cur_pk[x]  = pkts[idx];
                end
            end
            step(1'b0, 4'b0000, 1'b0, 1'b0, 64'h0);
            if (cur_req != 4'b0000) idx++;
        end
        sent = idx;
    endtask

    initial begin
        logic [DW-1:0] pk_list[$];
        int            sent;

        reset = 1'b1;
        cur_rst = 1'b1; cur_req = 4'b0000; cur_ds = 1'b0;
        for (int x = 0; x < 4; x++) cur_pk[x] = '0;
        bus.E_req = 1'b0; bus.N_req = 1'b0; bus.S_req = 1'b0; bus.PE_req = 1'b0;
        bus.E_packet = '0; bus.N_packet = '0; bus.S_packet = '0; bus.PE_packet = '0;
        bus.ds_full = 1'b0;

        // req/full bit order {PE,S,N,E}; input x drives pkt | (x << 32)
        tbl[0]  = '{1'b1, 4'b0000, 64'h0,  1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 64'h0};
        tbl[1]  = '{1'b0, 4'b0000, 64'h0,  1'b0, 1'b1, 4'b1110, 1'b0, 1'b1, 64'h0};
        tbl[2]  = '{1'b0, 4'b0000, 64'h0,  1'b0, 1'b1, 4'b1101, 1'b0, 1'b1, 64'h0};
        tbl[3]  = '{1'b0, 4'b0100, 64'hA5, 1'b0, 1'b1, 4'b1011, 1'b0, 1'b0, 64'h0};
        tbl[4]  = '{1'b0, 4'b0000, 64'h0,  1'b0, 1'b1, 4'b0111, 1'b1, 1'b1, 64'h0000_0002_0000_00A5};
        tbl[5]  = '{1'b0, 4'b0001, 64'h11, 1'b1, 1'b1, 4'b1110, 1'b0, 1'b0, 64'h0};
        tbl[6]  = '{1'b0, 4'b0010, 64'h22, 1'b1, 1'b1, 4'b1101, 1'b0, 1'b1, 64'h11};
        tbl[7]  = '{1'b0, 4'b0100, 64'h33, 1'b0, 1'b1, 4'b1011, 1'b1, 1'b1, 64'h11};
        tbl[8]  = '{1'b0, 4'b0000, 64'h0,  1'b0, 1'b1, 4'b0111, 1'b1, 1'b1, 64'h0000_0001_0000_0022};
        tbl[9]  = '{1'b1, 4'b0000, 64'h0,  1'b0, 1'b1, 4'b1110, 1'b1, 1'b1, 64'h0000_0002_0000_0033};
        tbl[10] = '{1'b0, 4'b0000, 64'h0,  1'b0, 1'b1, 4'b1110, 1'b0, 1'b1, 64'h0};

        @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            cur_rst = tbl[i].rst;
            cur_req = tbl[i].req;
            cur_ds  = tbl[i].ds;
            for (int x = 0; x < 4; x++) cur_pk[x] = tbl[i].pkt | (64'(x) << 32);
            step(tbl[i].chk, tbl[i].e_full, tbl[i].e_wr, tbl[i].chk_pkt, tbl[i].e_pkt);
        end

        // Each input holds one packet: downstream order 1,2,3,4
        idle(1'b1, 1'b0, 1);
        emitted.delete();
        pk_list = '{64'd1, 64'd2, 64'd3, 64'd4};
        stream(pk_list, 1'b0, 7, sent);
        check("order_count", 64'(emitted.size()), 64'd4);
        for (int k = 0; k < 4; k++)
            check("order_pkt", (k < emitted.size()) ? emitted[k] : 64'hX, 64'(k + 1));

        // Downstream blocked: four accepted, token frozen, then in-order drain
        idle(1'b1, 1'b0, 1);
        emitted.delete();
        pk_list = '{64'h100, 64'h101, 64'h102, 64'h103, 64'h104};
        stream(pk_list, 1'b1, 10, sent);
        check("ds_hold_accepted", 64'(sent), 64'd4);
        check("ds_hold_full", 64'(dut_full_s), 64'hF);
        check("ds_hold_no_wr", 64'(bus.out_wr_en), 64'd0);
        idle(1'b0, 1'b0, 6);
        check("drain_count", 64'(emitted.size()), 64'd4);
        for (int k = 0; k < 4; k++)
            check("drain_pkt", (k < emitted.size()) ? emitted[k] : 64'hX, 64'h100 + 64'(k));

        // Reset with three buffered packets: nothing stale ever emitted
        idle(1'b1, 1'b0, 1);
        pk_list = '{64'hD0, 64'hD1, 64'hD2};
        stream(pk_list, 1'b1, 3, sent);
        emitted.delete();
        idle(1'b1, 1'b1, 1);
        check("rst_full", 64'(dut_full_s), 64'hE);
        check("rst_wr_en", 64'(bus.out_wr_en), 64'd0);
        idle(1'b0, 1'b0, 6);
        check("rst_no_stale", 64'(emitted.size()), 64'd0);

        // Random traffic against the model
        for (int k = 0; k < 3000; k++) begin
            cur_rst = ($urandom_range(0, 299) == 0);
            cur_ds  = (k % 400 < 150) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            cur_req = 4'b0000;
            for (int x = 0; x < 4; x++) cur_pk[x] = {$urandom, $urandom};
            if (!cur_rst && mq.size() < DEPTH && $urandom_range(0, 3) != 0)
                cur_req[m_owner] = 1'b1;
            step(1'b0, 4'b0000, 1'b0, 1'b0, 64'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
